// File: rtl/regfile_sb.sv
// regfile_sb
//   Y86-64 register file for the pipelined core. It has two combinational
//   read ports (decode srcA/srcB) and two write ports (E and M write-back).
//   A per-register pending-write scoreboard raises stall on read-after-write
//   hazards.
//
// Optional feature (compile-time macro): REGFILE_BYPASS_EN
//   defined   : same-cycle write-through on both read ports (M beats E).
//               A read whose only pending writer is retiring this cycle is
//               not stalled.
//   undefined : reads return the stored register only, and any nonzero
//               pending count stalls the read.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   srcA/srcB  read indices; RNONE or >= NREGS reads as 0
//   valA/valB  combinational read data (0 while in reset)
//   dstE/valE  E write-back index/data (RNONE = no write)
//   dstM/valM  M write-back index/data (RNONE = no write, M wins over E)
//   rsv_valid  decode reserves rsv_dst for a future write-back
//   rsv_dst    register being reserved
//   rsv_ready  low when the counter for rsv_dst is saturated (reservation dropped)
//   stall      a source register has an unresolved pending write
//   regs_flat  snapshot of all registers, reg i at [i*DW +: DW]
module regfile_sb #(
  parameter int              DW      = 64,
  parameter int              NREGS   = 15,
  parameter int              AW      = 4,
  parameter logic [AW-1:0]   RNONE   = {AW{1'b1}},
  parameter int              SP_IDX  = 4,
  parameter logic [DW-1:0]   SP_INIT = '0,
  parameter int              CW      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       srcA,
  input  logic [AW-1:0]       srcB,
  output logic [DW-1:0]       valA,
  output logic [DW-1:0]       valB,
  input  logic [AW-1:0]       dstE,
  input  logic [DW-1:0]       valE,
  input  logic [AW-1:0]       dstM,
  input  logic [DW-1:0]       valM,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_dst,
  output logic                rsv_ready,
  output logic                stall,
  output logic [NREGS*DW-1:0] regs_flat
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [DW-1:0] regs [NREGS];
  logic [CW-1:0] cnt  [NREGS];

  // One-hot per-register decodes. Indices at or above NREGS (including
  // RNONE) match nothing, so they never read, write or reserve.
  logic [NREGS-1:0] wr_e, wr_m, dec, sel_a, sel_b, sel_r, inc;
  logic             rsv_ok;

  always_comb begin
    wr_e  = '0;
    wr_m  = '0;
    dec   = '0;
    sel_a = '0;
    sel_b = '0;
    sel_r = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_e[i]  = (dstE == AW'(i)) && (dstE != RNONE);
      wr_m[i]  = (dstM == AW'(i)) && (dstM != RNONE);
      dec[i]   = wr_e[i] | wr_m[i];
      sel_a[i] = (srcA == AW'(i)) && (srcA != RNONE);
      sel_b[i] = (srcB == AW'(i)) && (srcB != RNONE);
      sel_r[i] = (rsv_dst == AW'(i)) && (rsv_dst != RNONE);
    end
  end

  // A saturated counter can still take a reservation when a write-back to
  // the same register retires in the same cycle, because the net change is 0.
  always_comb begin
    rsv_ok = 1'b1;
    inc    = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_r[i] && (cnt[i] == CNT_MAX) && !dec[i]) rsv_ok = 1'b0;
    end
    for (int i = 0; i < NREGS; i++) begin
      inc[i] = rsv_valid & rsv_ok & sel_r[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_m[i])      regs[i] <= valM;
        else if (wr_e[i]) regs[i] <= valE;
        if (inc[i] && !dec[i])                      cnt[i] <= cnt[i] + CW'(1);
        else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Read muxes and per-port pending detection. A pending count of exactly
  // one that is retiring this cycle is the only case bypass can resolve.
  logic [DW-1:0] rd_a, rd_b;
  logic          pend_a, pend_b;

  always_comb begin
    rd_a   = '0;
    rd_b   = '0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_a[i]) begin
`ifdef REGFILE_BYPASS_EN
        rd_a   = wr_m[i] ? valM : (wr_e[i] ? valE : regs[i]);
        pend_a = (cnt[i] != '0) && !((cnt[i] == CW'(1)) && dec[i]);
`else
        rd_a   = regs[i];
        pend_a = (cnt[i] != '0);
`endif
      end
      if (sel_b[i]) begin
`ifdef REGFILE_BYPASS_EN
        rd_b   = wr_m[i] ? valM : (wr_e[i] ? valE : regs[i]);
        pend_b = (cnt[i] != '0) && !((cnt[i] == CW'(1)) && dec[i]);
`else
        rd_b   = regs[i];
        pend_b = (cnt[i] != '0);
`endif
      end
    end
  end

  assign valA      = rst_n ? rd_a : '0;
  assign valB      = rst_n ? rd_b : '0;
  assign stall     = rst_n & (pend_a | pend_b);
  assign rsv_ready = !rst_n | rsv_ok;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*DW +: DW] = regs[g];
  end

endmodule
